hc85_cascade_seq: RTL

Sequencer that compares two WIDTH-bit operands using one external 4-bit HC85-style magnitude comparator.
- Feeds the comparator one nibble per clock, LSB nibble first.
- Routes each registered result back into the comparator's cascade inputs for the next more-significant nibble.
- Presents a registered, one-hot A>B / A<B / A=B result with a done pulse.
- Sits between a requesting controller and the HC85 instance; it owns all HC85 inputs.

---
 rtl/hc85_cascade_seq.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/hc85_cascade_seq.sv
// Purpose: walks two WIDTH-bit operands through one external 4-bit HC85 comparator, LSB nibble first, chaining cascade.
// Latency: START accepted at edge 0, NIB RUN cycles, one FIN cycle; DONE and result visible after edge NIB+1.
// Backpressure: none; START is only accepted in IDLE and ignored while BUSY is high.
module hc85_cascade_seq #(
  parameter int WIDTH = 16,
  parameter int NIB   = WIDTH / 4,
  parameter int IW    = (NIB > 1) ? $clog2(NIB) : 1
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             START,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             BUSY,
  output logic             DONE,
  output logic             QAGB,
  output logic             QASB,
  output logic             QAEB,
  output logic             ERR,
  output logic [3:0]       CA,
  output logic [3:0]       CB,
  output logic             CIAGB,
  output logic             CIASB,
  output logic             CIAEB,
  input  logic             CQAGB,
  input  logic             CQASB,
  input  logic             CQAEB
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIN  = 2'd2
  } state_t;

  localparam logic [IW-1:0] LAST_IDX = IW'(NIB - 1);

  state_t           r_state;
  logic [IW-1:0]    r_idx;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  // Running cascade triple: result of all nibbles compared so far.
  logic             r_g;
  logic             r_s;
  logic             r_e;
  logic             r_qagb;
  logic             r_qasb;
  logic             r_qaeb;
  logic             r_err;
  logic             r_done;

  logic [WIDTH-1:0] w_a_sh;
  logic [WIDTH-1:0] w_b_sh;
  logic             w_run;
  logic             w_onehot;

  assign w_run = (r_state == S_RUN);

  // The accumulated triple must be exactly one of greater/smaller/equal.
  assign w_onehot = ({r_g, r_s, r_e} == 3'b100) ||
                    ({r_g, r_s, r_e} == 3'b010) ||
                    ({r_g, r_s, r_e} == 3'b001);

  // Select the current nibble by shifting it down to the bottom.
  always_comb begin
    w_a_sh = r_a >> {r_idx, 2'b00};
    w_b_sh = r_b >> {r_idx, 2'b00};
  end

  // Comparator drive: active nibble and cascade in RUN, neutral "equal" otherwise.
  always_comb begin
    CA    = 4'd0;
    CB    = 4'd0;
    CIAGB = 1'b0;
    CIASB = 1'b0;
    CIAEB = 1'b1;
    if (w_run) begin
      CA    = w_a_sh[3:0];
      CB    = w_b_sh[3:0];
      CIAGB = r_g;
      CIASB = r_s;
      CIAEB = r_e;
    end
  end

  // Sequencer FSM with registered result, error and done outputs.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state <= S_IDLE;
      r_idx   <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_g     <= 1'b0;
      r_s     <= 1'b0;
      r_e     <= 1'b1;
      r_qagb  <= 1'b0;
      r_qasb  <= 1'b0;
      r_qaeb  <= 1'b0;
      r_err   <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (START) begin
            r_a     <= A;
            r_b     <= B;
            r_idx   <= '0;
            r_g     <= 1'b0;
            r_s     <= 1'b0;
            r_e     <= 1'b1;
            r_state <= S_RUN;
          end
        end
        S_RUN: begin
          // Comparator output for this nibble becomes cascade for the next one up.
          r_g <= CQAGB;
          r_s <= CQASB;
          r_e <= CQAEB;
          if (r_idx == LAST_IDX) begin
            r_state <= S_FIN;
          end else begin
            r_idx <= r_idx + 1'b1;
          end
        end
        S_FIN: begin
          r_qagb  <= r_g;
          r_qasb  <= r_s;
          r_qaeb  <= r_e;
          r_err   <= ~w_onehot;
          r_done  <= 1'b1;
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign BUSY = (r_state != S_IDLE);
  assign DONE = r_done;
  assign QAGB = r_qagb;
  assign QASB = r_qasb;
  assign QAEB = r_qaeb;
  assign ERR  = r_err;

endmodule
